// File: rtl/mux16_arbiter_pkg.sv
// Shared types and constants for the two-requester 16-bit mux arbiter.
package mux16_pkg;
  localparam int WIDTH = 16;

  typedef enum logic {EMPTY, FULL} arb_state_t;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;
endpackage

// File: rtl/mux16_arbiter_if.sv
// Handshake bundle: two producer channels, one consumer channel, live select.
interface mux16_arbiter_if;
  import mux16_pkg::*;

  logic             a_valid;
  logic [WIDTH-1:0] a_data;
  logic             a_ready;
  logic             b_valid;
  logic [WIDTH-1:0] b_data;
  logic             b_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic             out_src;
  logic             sel;

  modport master (
    input  a_valid, a_data, b_valid, b_data, out_ready,
    output a_ready, b_ready, out_valid, out_data, out_src, sel
  );

  modport slave (
    output a_valid, a_data, b_valid, b_data, out_ready,
    input  a_ready, b_ready, out_valid, out_data, out_src, sel
  );
endinterface

// File: rtl/mux_16.sv
// 16-bit 2:1 mux datapath; select=0 passes a, select=1 passes b.
module mux_16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        select,
  output logic [15:0] out
);
  assign out = select ? b : a;
endmodule

// File: rtl/mux16_arbiter.sv
// Arbitrates A/B onto the shared 16-bit mux and registers the winner into a
// one-entry valid/ready output stage.
module mux16_arbiter #(
  parameter int WIDTH      = 16,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  mux16_arbiter_if.master bus
);
  import mux16_pkg::*;

  arb_state_t       state, nxt;
  logic             last_grant;
  logic             sel;
  logic             accept;
  logic             xfer;
  logic [WIDTH-1:0] mux_out;

  // With no requester, sel parks on the last grant so it is never X.
  always_comb begin
    sel = last_grant;
    case ({bus.a_valid, bus.b_valid})
      2'b10:   sel = SRC_A;
      2'b01:   sel = SRC_B;
      2'b11:   sel = FIXED_PRIO ? SRC_A : ~last_grant;
      default: sel = last_grant;
    endcase
  end

  assign accept      = (state == EMPTY) | (bus.out_ready & bus.out_valid);
  assign bus.a_ready = accept & bus.a_valid & (sel == SRC_A);
  assign bus.b_ready = accept & bus.b_valid & (sel == SRC_B);
  assign xfer        = bus.a_ready | bus.b_ready;
  assign bus.sel     = sel;
  assign bus.out_valid = (state == FULL);

  mux_16 u_mux (
    .a      (bus.a_data),
    .b      (bus.b_data),
    .select (sel),
    .out    (mux_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= nxt;
  end

  // A load wins over a drain so back-to-back words keep the stage full.
  always_comb begin
    nxt = state;
    if (xfer)                                 nxt = FULL;
    else if (state == FULL && bus.out_ready)  nxt = EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_data <= '0;
      bus.out_src  <= SRC_A;
      last_grant   <= SRC_B;
    end else if (xfer) begin
      bus.out_data <= mux_out;
      bus.out_src  <= sel;
      last_grant   <= sel;
    end
  end
endmodule

// File: tb/tb_mux16_arbiter.sv
// Scoreboard bench: round-robin and fixed-priority instances share stimulus;
// a rule-level model predicts grants, a monitor checks delivered words.
module tb_mux16_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_valid = 1'b0, b_valid = 1'b0, out_ready = 1'b0;
  logic [15:0] a_data = '0, b_data = '0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mux16_arbiter_if bus0 ();
  mux16_arbiter_if bus1 ();

  assign bus0.a_valid = a_valid;  assign bus1.a_valid = a_valid;
  assign bus0.a_data  = a_data;   assign bus1.a_data  = a_data;
  assign bus0.b_valid = b_valid;  assign bus1.b_valid = b_valid;
  assign bus0.b_data  = b_data;   assign bus1.b_data  = b_data;
  assign bus0.out_ready = out_ready; assign bus1.out_ready = out_ready;

  mux16_arbiter #(.WIDTH(16), .FIXED_PRIO(1'b0)) dut_rr (.clk(clk), .rst_n(rst_n), .bus(bus0));
  mux16_arbiter #(.WIDTH(16), .FIXED_PRIO(1'b1)) dut_fp (.clk(clk), .rst_n(rst_n), .bus(bus1));

  logic [1:0]       ov, ar, br, sl, os;
  logic [1:0][15:0] od;
  assign ov = {bus1.out_valid, bus0.out_valid};
  assign ar = {bus1.a_ready,   bus0.a_ready};
  assign br = {bus1.b_ready,   bus0.b_ready};
  assign sl = {bus1.sel,       bus0.sel};
  assign os = {bus1.out_src,   bus0.out_src};
  assign od = {bus1.out_data,  bus0.out_data};

  task automatic chk(input string nm, input int m, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", nm, m, $time, act, exp);
    end
  endtask

  // Reference model: m=0 round-robin, m=1 A-priority. Queues hold {src, data}.
  logic [16:0] q0[$], q1[$];
  logic [1:0]  m_full = 2'b00;
  logic [1:0]  m_last = 2'b11;

  initial begin
    logic acc, s, g;
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        m_full = 2'b00; m_last = 2'b11; q0.delete(); q1.delete();
      end else begin
        for (int m = 0; m < 2; m++) begin
          chk("out_valid", m, 32'(ov[m]), 32'(m_full[m]));
          acc = !m_full[m] || out_ready;
          if (a_valid && b_valid) s = (m == 1) ? 1'b0 : !m_last[m];
          else if (a_valid)       s = 1'b0;
          else if (b_valid)       s = 1'b1;
          else                    s = m_last[m];
          g = acc && (a_valid || b_valid);
          chk("sel", m, 32'(sl[m]), 32'(s));
          chk("a_ready", m, 32'(ar[m]), 32'(g && !s));
          chk("b_ready", m, 32'(br[m]), 32'(g && s));
          if (g) begin
            if (m == 0) q0.push_back({s, s ? b_data : a_data});
            else        q1.push_back({s, s ? b_data : a_data});
            m_last[m] = s;
            m_full[m] = 1'b1;
          end else if (m_full[m] && out_ready) begin
            m_full[m] = 1'b0;
          end
        end
      end
    end
  end

  // Monitor: consume a word on every output handshake; check stall stability.
  logic [1:0]       stalled = 2'b00;
  logic [1:0][16:0] held;
  initial begin
    logic [16:0] exp;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int m = 0; m < 2; m++) begin
          if (stalled[m] && ov[m])
            chk("stall_hold", m, 32'({os[m], od[m]}), 32'(held[m]));
          if (ov[m] && out_ready) begin
            if ((m == 0 ? q0.size() : q1.size()) == 0) begin
              chk("unexpected_word", m, 32'({os[m], od[m]}), 32'h0);
            end else begin
              exp = (m == 0) ? q0.pop_front() : q1.pop_front();
              chk("out_word", m, 32'({os[m], od[m]}), 32'(exp));
            end
          end
          stalled[m] = ov[m] && !out_ready;
          held[m]    = {os[m], od[m]};
        end
      end else begin
        stalled = 2'b00;
      end
    end
  end

  task automatic drive(input logic av, input logic [15:0] ad, input logic bv,
                       input logic [15:0] bd, input logic ordy, input int n);
    a_valid = av; a_data = ad; b_valid = bv; b_data = bd; out_ready = ordy;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #1;
    chk("rst_out_valid", 0, 32'(ov), 32'h0);
    chk("rst_out_data", 0, 32'(od), 32'h0);
    chk("rst_out_src", 0, 32'(os), 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    drive(1, 16'h5555, 0, 16'h0000, 1, 1);   // single A word
    drive(0, 16'h0000, 0, 16'h0000, 1, 2);
    drive(1, 16'h5555, 1, 16'hAAAA, 1, 4);   // contention: RR alternates, FP all A
    drive(0, 16'h0000, 1, 16'h1234, 1, 1);   // B loads 1234
    drive(1, 16'h4321, 0, 16'h0000, 0, 3);   // stall with A waiting
    drive(1, 16'h4321, 0, 16'h0000, 1, 1);
    drive(0, 16'h0000, 0, 16'h0000, 1, 2);

    // Reset while holding a word: out_valid must drop without a clock edge.
    drive(1, 16'h7777, 0, 16'h0000, 0, 2);
    @(negedge clk); #2 rst_n = 1'b0;
    #1 chk("async_rst_valid", 0, 32'(ov), 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    drive(1, 16'h5555, 1, 16'hAAAA, 1, 2);   // A first after reset

    drive(1, 16'h5555, 0, 16'h0000, 1, 1);   // one A transfer, then idle
    drive(0, 16'h0000, 0, 16'h0000, 1, 5);
    drive(1, 16'h5555, 1, 16'hAAAA, 1, 2);   // RR grants B next

    for (int i = 0; i < 400; i++)
      drive(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
            16'($urandom), 1'($urandom_range(0, 3) != 0), 1);
    for (int i = 0; i < 200; i++)
      drive(1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom_range(0, 3) != 0),
            16'($urandom), 1'($urandom_range(0, 1)), 1);

    drive(0, 16'h0000, 0, 16'h0000, 1, 3);
    chk("drain_q0", 0, 32'(q0.size()), 32'h0);
    chk("drain_q1", 1, 32'(q1.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
